// File: rtl/tpu_pkg.sv
// Shared definitions for the systolic-array front end (feeders and de-skewer).
// Contents: default activation width, feeder state encoding, skew-length helpers.
package tpu_pkg;

    localparam int unsigned ACT_W = 8;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } feeder_state_e;

    // Number of beats needed to push an n-wide tile diagonally through the array.
    function automatic int unsigned skew_len(input int unsigned n);
        return 2 * n - 1;
    endfunction

    // Width of a beat index register covering 0 .. skew_len(n)-1 (never zero).
    function automatic int unsigned beat_idx_w(input int unsigned n);
        return (skew_len(n) > 1) ? $clog2(skew_len(n)) : 1;
    endfunction

endpackage

// File: rtl/skew_beat_sel.sv
// Combinational beat selector for the skewed activation feeder.
// Lane r of beat k carries tile element A[r][k-r] when 0 <= k-r < N, else zero.
// Ports:
//   tile_i  N*N*DATA_W  latched tile, row-major, A[r][c] at (r*N+c)*DATA_W
//   k_i     KW          beat index
//   beat_o  N*DATA_W    lane vector, lane r at r*DATA_W
module skew_beat_sel
    import tpu_pkg::*;
#(
    parameter int unsigned N      = 2,
    parameter int unsigned DATA_W = ACT_W,
    parameter int unsigned KW     = beat_idx_w(N)
) (
    input  logic [N*N*DATA_W-1:0] tile_i,
    input  logic [KW-1:0]         k_i,
    output logic [N*DATA_W-1:0]   beat_o
);

    // Element (r,c) sits on anti-diagonal r+c; everything else is padding.
    always_comb begin
        beat_o = '0;
        for (int r = 0; r < int'(N); r++) begin
            for (int c = 0; c < int'(N); c++) begin
                if (int'(k_i) == r + c) begin
                    beat_o[r*DATA_W +: DATA_W] = tile_i[(r*N+c)*DATA_W +: DATA_W];
                end
            end
        end
    end

endmodule

// File: rtl/input_skew_feeder.sv
// Activation feeder for an N x N systolic array.
// Accepts a whole tile over valid/ready, then streams 2N-1 diagonally skewed
// beats under array-side advance/stall, accepting the next tile on the last
// beat so consecutive tiles flow without a bubble.
// Ports:
//   clk, reset           clock, asynchronous active-high reset
//   in_valid/in_ready    tile handshake (in_ready is combinational)
//   in_data              N*N*DATA_W tile, row-major
//   advance              array consumes the current beat; low stalls
//   out_valid/out_data   registered beat, lane r at r*DATA_W
//   out_first/out_last   beat 0 / beat 2N-2 markers
//   busy                 feeder is streaming
module input_skew_feeder
    import tpu_pkg::*;
#(
    parameter int unsigned N      = 2,
    parameter int unsigned DATA_W = ACT_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [N*N*DATA_W-1:0] in_data,
    input  logic                  advance,
    output logic                  out_valid,
    output logic [N*DATA_W-1:0]   out_data,
    output logic                  out_first,
    output logic                  out_last,
    output logic                  busy
);

    localparam int unsigned KW     = beat_idx_w(N);
    localparam int unsigned TILE_W = N * N * DATA_W;
    localparam int unsigned BEAT_W = N * DATA_W;
    localparam logic [KW-1:0] K_LAST = KW'(skew_len(N) - 1);

    feeder_state_e      state_q, state_d;
    logic [KW-1:0]      k_q, k_d;
    logic [TILE_W-1:0]  tile_q, tile_d;
    logic               out_valid_q, out_valid_d;
    logic [BEAT_W-1:0]  out_data_q, out_data_d;
    logic               out_first_q, out_first_d;
    logic               out_last_q, out_last_d;
    logic               busy_q, busy_d;

    logic               transfer;
    logic               load_beat;
    logic               drop_beat;
    logic [BEAT_W-1:0]  next_beat;

    // Ready only when idle or when the final beat is being consumed.
    assign in_ready = !reset &&
                      ((state_q == IDLE) ||
                       ((state_q == STREAM) && (k_q == K_LAST) && advance));
    assign transfer = in_valid && in_ready;

    // Beat selection works on next-state tile/index so outputs stay registered.
    skew_beat_sel #(
        .N      (N),
        .DATA_W (DATA_W),
        .KW     (KW)
    ) u_beat_sel (
        .tile_i (tile_d),
        .k_i    (k_d),
        .beat_o (next_beat)
    );

    // Next-state logic: tile capture, beat stepping, end-of-tile handling.
    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        tile_d    = tile_q;
        load_beat = 1'b0;
        drop_beat = 1'b0;

        case (state_q)
            IDLE: begin
                if (transfer) begin
                    state_d   = STREAM;
                    tile_d    = in_data;
                    k_d       = '0;
                    load_beat = 1'b1;
                end
            end
            STREAM: begin
                if (advance) begin
                    if (k_q == K_LAST) begin
                        if (transfer) begin
                            tile_d    = in_data;
                            k_d       = '0;
                            load_beat = 1'b1;
                        end else begin
                            state_d   = IDLE;
                            k_d       = '0;
                            drop_beat = 1'b1;
                        end
                    end else begin
                        k_d       = k_q + KW'(1);
                        load_beat = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                k_d     = '0;
            end
        endcase
    end

    // Next output values: load a fresh beat, clear on return to idle, else hold.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_first_d = out_first_q;
        out_last_d  = out_last_q;
        busy_d      = busy_q;

        if (load_beat) begin
            out_valid_d = 1'b1;
            out_data_d  = next_beat;
            out_first_d = (k_d == '0);
            out_last_d  = (k_d == K_LAST);
            busy_d      = 1'b1;
        end else if (drop_beat) begin
            out_valid_d = 1'b0;
            out_data_d  = '0;
            out_first_d = 1'b0;
            out_last_d  = 1'b0;
            busy_d      = 1'b0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            k_q         <= '0;
            tile_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_first_q <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            tile_q      <= tile_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_first_q <= out_first_d;
            out_last_q  <= out_last_d;
            busy_q      <= busy_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_first = out_first_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;

endmodule

// File: doc/input_skew_feeder.md
Name: input_skew_feeder

Overview:
- Parametrised activation feeder for an N×N systolic array.
- Accepts a full N×N activation tile over a valid/ready handshake and latches it internally.
- Streams the tile as 2N-1 diagonally skewed beats: lane r is delayed r cycles and zero-padded at both ends.
- Adds an array-side advance/stall control and back-to-back tile acceptance, so the array sees a gap-free stream of tiles.

Parameters:
- N, 2, array dimension: number of lanes, and rows/columns of the tile.
- DATA_W, 8, activation width in bits.

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- in_valid  in  1  tile offered on in_data
- in_ready  out  1  feeder accepts the tile this cycle
- in_data  in  N*N*DATA_W  tile, row-major; element A[r][c] at bits [(r*N+c)*DATA_W +: DATA_W]
- advance  in  1  array consumes the current beat; low = stall
- out_valid  out  1  out_data holds a live beat
- out_data  out  N*DATA_W  lane r at bits [r*DATA_W +: DATA_W]
- out_first  out  1  current beat is beat 0 of a tile
- out_last  out  1  current beat is beat 2N-2 of a tile
- busy  out  1  state is STREAM

Behaviour:
- States:
  - IDLE: out_valid=0, out_data=0, out_first=0, out_last=0, busy=0.
  - STREAM: beat index k in 0..2N-2 is held in a register of width max(1,$clog2(2N-1)).
- Beat content:
  - Lane r at beat k = A[r][k-r] when 0 <= k-r < N, else 0.
  - Example, N=2: beats (A00,0), (A01,A10), (0,A11).
- Handshake:
  - A transfer occurs when in_valid && in_ready.
  - in_ready = !reset && (IDLE || (STREAM && k==2N-2 && advance)). It is combinational and has no dependency on in_valid.
- Latency:
  - On a transfer at edge t, the tile is latched and beat 0 is registered onto the outputs at that same edge.
  - Beat 0 is therefore visible in the cycle after the handshake cycle, with out_first=1.
- All outputs are registered; no combinational path from in_data to out_data.
- STREAM stepping:
  - advance=1, k<2N-2: k <= k+1; outputs update to the next beat.
  - advance=0: k, the latched tile and all outputs hold. in_ready=0 during a stall, including on the last beat.
  - k==2N-2, advance=1, transfer: latch the new tile, k <= 0, stay in STREAM. No bubble.
  - k==2N-2, advance=1, no transfer: go to IDLE and zero the outputs.
- In IDLE, advance is ignored; acceptance does not depend on advance.
- in_valid while in_ready=0: ignored. The tile is not latched and the current stream is unaffected.
- N=1: a single beat; out_first=out_last=1 on it.
- Reset (any time, including mid-stream):
  - Go to IDLE immediately; k=0.
  - Tile register is cleared to 0.
  - All outputs are 0.
  - The first acceptance is possible in the first cycle after deassertion.
- Width: data passes through unmodified; no arithmetic on activations.

Decomposition:
- Shared package tpu_pkg:
  - ACT_W default constant (8), from which DATA_W defaults.
  - Feeder state enum (IDLE, STREAM).
  - Function skew_len(n) = 2n-1, reused by the weight feeder and the output de-skewer.
- Sub-module skew_beat_sel (purely combinational):
  - Inputs: latched tile, beat index.
  - Output: next out_data lane vector, including the zero padding.
  - Instantiated once; the FSM and registers stay in input_skew_feeder.

Test Plan:
- N=2, DATA_W=8, tile [[1,2],[3,4]], advance=1:
  - in_ready=1 in IDLE.
  - Next three cycles: out_data lanes (1,0), (2,3), (0,4).
  - out_first on the first beat, out_last on the third, then IDLE with outputs 0.
- N=3, tile 1..9 row-major, advance low for 2 cycles on beat 2:
  - Beat 2 = (3,5,7) is held for 3 cycles; k frozen; in_ready=0.
  - Remaining beats: (0,6,8), (0,0,9).
- N=2, second tile [[5,6],[7,8]] offered during the first tile:
  - in_ready=0 until the last beat; the handshake completes on beat (0,4).
  - Next cycle shows (5,0) with out_first=1; no bubble between tiles.
- N=3, reset asserted asynchronously on beat 1:
  - Outputs go to 0 and busy=0 immediately.
  - After deassertion, in_ready=1; a new tile streams from beat 0 with no leftover data.
- N=1, tile [42]:
  - One beat of lane value 42 with out_first=out_last=1, then IDLE.
